// File: rtl/apb_req_pkg.sv
// Shared types and constants for the APB requester bridge.
package apb_req_pkg;

  // Transfer sequencing states, one transfer outstanding at a time.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Bit positions within pprot.
  localparam int PPROT_PRIV  = 0;
  localparam int PPROT_NSEC  = 1;
  localparam int PPROT_INSTR = 2;

endpackage

// File: rtl/apb_req_timer.sv
// Access-phase timeout counter. expired pulses on the ACCESS cycle whose
// stall would bring the count up to TIMEOUT_CYCLES, so the FSM can abort
// on that same edge. A limit of 0 removes the counter entirely.
module apb_req_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic pclk,
  input  logic preset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timer
      // Inputs are intentionally left unused when the timeout is disabled.
      logic w_unused_ok;
      assign w_unused_ok = ^{pclk, preset, clear, enable};
      assign expired     = 1'b0;
    end else begin : g_timer
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] r_count;

      // Count stalled ACCESS cycles; cleared when a new transfer starts.
      always_ff @(posedge pclk) begin
        if (preset || clear) begin
          r_count <= '0;
        end else if (enable) begin
          r_count <= r_count + CW'(1);
        end
      end

      assign expired = enable && (r_count == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_requester.sv
// APB requester bridge: turns a valid/ready request into a single APB
// transfer and returns read data / error status on a valid/ready response.
module apb_requester
  import apb_req_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  input  logic [2:0]              req_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;

  state_e r_state;
  state_e w_state_next;

  logic                  w_accept;
  logic                  w_timer_enable;
  logic                  w_expired;

  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [STRB_W-1:0]     r_pstrb;
  logic [2:0]            r_pprot;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_rsp_timeout;

  // Only stalled ACCESS cycles count toward the timeout, so pready on the
  // limit edge keeps enable low and the transfer completes normally.
  assign w_timer_enable = (r_state == ACCESS) && !pready;

  apb_req_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .pclk   (pclk),
    .preset (preset),
    .clear  (w_accept),
    .enable (w_timer_enable),
    .expired(w_expired)
  );

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and state-decoded handshake/APB control outputs.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    psel         = 1'b0;
    penable      = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept     = 1'b1;
          w_state_next = SETUP;
        end
      end
      SETUP: begin
        psel         = 1'b1;
        w_state_next = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready || w_expired) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Request capture on acceptance and response capture at the end of ACCESS.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_paddr       <= '0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_pprot       <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_paddr  <= req_addr;
        r_pwrite <= req_write;
        r_pwdata <= req_wdata;
        r_pstrb  <= req_write ? req_strb : '0;
        r_pprot  <= req_prot;
      end
      if (r_state == ACCESS) begin
        if (pready) begin
          r_rsp_rdata   <= r_pwrite ? '0 : prdata;
          r_rsp_err     <= pslverr;
          r_rsp_timeout <= 1'b0;
        end else if (w_expired) begin
          r_rsp_rdata   <= '0;
          r_rsp_err     <= 1'b1;
          r_rsp_timeout <= 1'b1;
        end
      end
    end
  end

  assign paddr       = r_paddr;
  assign pwrite      = r_pwrite;
  assign pwdata      = r_pwdata;
  assign pstrb       = r_pstrb;
  assign pprot       = r_pprot;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule
